// File: rtl/param_digital_lock.sv
// Parametrised code lock. Collects one-hot button presses into an N-digit entry,
// compares it against a stored code and manages the OPEN, FAIL, LOCKOUT and PROG
// states. The four flag outputs are bits of the state register.
module param_digital_lock #(
    parameter int NUM_BUTTONS    = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*$clog2(NUM_BUTTONS)-1:0] DEFAULT_CODE = 8'hE4,
    parameter int MAX_TRIES      = 3,
    parameter int ERR_CYCLES     = 1000,
    parameter int LOCKOUT_CYCLES = 100000,
    parameter int OPEN_CYCLES    = 50000,
    parameter int ENTRY_TIMEOUT  = 20000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_BUTTONS-1:0]           btn_pulse,
    input  logic                             relock,
    input  logic                             prog_req,
    output logic                             unlocked,
    output logic                             error,
    output logic                             lockout,
    output logic                             prog_mode,
    output logic [$clog2(CODE_LEN+1)-1:0]    entry_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic [3:0]                       led
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DW      = $clog2(NUM_BUTTONS);
    localparam int CW      = CODE_LEN * DW;
    localparam int ECW     = $clog2(CODE_LEN + 1);
    localparam int FCW     = $clog2(MAX_TRIES + 1);
    localparam int MAX_CYC = max_of(max_of(max_of(ERR_CYCLES, LOCKOUT_CYCLES), OPEN_CYCLES), ENTRY_TIMEOUT);
    localparam int TW      = $clog2(MAX_CYC + 1);

    // Low four bits of each encoding are the {prog_mode, lockout, error, unlocked} flags.
    typedef enum logic [4:0] {
        S_LOCKED  = 5'b00000,
        S_OPEN    = 5'b00001,
        S_FAIL    = 5'b00010,
        S_LOCKOUT = 5'b00100,
        S_PROG    = 5'b01000,
        S_CHECK   = 5'b10000
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_code;
    logic [CW-1:0]   r_buf;
    logic [ECW-1:0]  r_entry_cnt;
    logic [FCW-1:0]  r_fail_cnt;
    logic [TW-1:0]   r_timer;

    logic            w_valid;
    logic [DW-1:0]   w_digit;
    logic [CW-1:0]   w_buf_next;
    logic            w_last;
    logic            w_expire;

    // Decode the press: only a single set bit counts as a digit.
    always_comb begin
        w_digit = '0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            if (btn_pulse[k]) begin
                w_digit = DW'(k);
            end
        end
        w_valid = $onehot(btn_pulse);
    end

    // Entry buffer with the current digit already merged, so PROG can commit it on the final press.
    always_comb begin
        w_buf_next = r_buf;
        if (int'(r_entry_cnt) < CODE_LEN) begin
            w_buf_next[int'(r_entry_cnt)*DW +: DW] = w_digit;
        end
    end

    assign w_last   = (int'(r_entry_cnt) == CODE_LEN - 1);
    assign w_expire = (r_timer == TW'(1));

    // Lock state machine, shared down-counter, entry buffer and stored code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOCKED;
            r_code      <= DEFAULT_CODE;
            r_buf       <= '0;
            r_entry_cnt <= '0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
        end else begin
            r_timer <= (r_timer != '0) ? r_timer - TW'(1) : '0;
            case (r_state)
                S_LOCKED, S_PROG: begin
                    if (w_valid) begin
                        r_buf   <= w_buf_next;
                        r_timer <= TW'(ENTRY_TIMEOUT);
                        if (!w_last) begin
                            r_entry_cnt <= r_entry_cnt + ECW'(1);
                        end else if (r_state == S_PROG) begin
                            r_code      <= w_buf_next;
                            r_entry_cnt <= '0;
                            r_state     <= S_LOCKED;
                        end else begin
                            r_entry_cnt <= r_entry_cnt + ECW'(1);
                            r_state     <= S_CHECK;
                        end
                    end else if (w_expire) begin
                        // A stale partial entry is discarded without counting as a failure.
                        r_entry_cnt <= '0;
                        if (r_state == S_PROG) begin
                            r_state <= S_LOCKED;
                            r_timer <= TW'(ENTRY_TIMEOUT);
                        end
                    end
                end
                S_CHECK: begin
                    r_entry_cnt <= '0;
                    if (r_buf == r_code) begin
                        r_fail_cnt <= '0;
                        r_state    <= S_OPEN;
                        r_timer    <= TW'(OPEN_CYCLES);
                    end else if (int'(r_fail_cnt) + 1 == MAX_TRIES) begin
                        r_fail_cnt <= '0;
                        r_state    <= S_LOCKOUT;
                        r_timer    <= TW'(LOCKOUT_CYCLES);
                    end else begin
                        r_fail_cnt <= r_fail_cnt + FCW'(1);
                        r_state    <= S_FAIL;
                        r_timer    <= TW'(ERR_CYCLES);
                    end
                end
                S_OPEN: begin
                    // relock takes priority over a simultaneous prog_req.
                    if (relock || w_expire) begin
                        r_state <= S_LOCKED;
                        r_timer <= TW'(ENTRY_TIMEOUT);
                    end else if (prog_req) begin
                        r_state <= S_PROG;
                        r_timer <= TW'(ENTRY_TIMEOUT);
                    end
                end
                S_FAIL, S_LOCKOUT: begin
                    if (w_expire) begin
                        r_state <= S_LOCKED;
                        r_timer <= TW'(ENTRY_TIMEOUT);
                    end
                end
                default: begin
                    r_state <= S_LOCKED;
                end
            endcase
        end
    end

    assign unlocked  = r_state[0];
    assign error     = r_state[1];
    assign lockout   = r_state[2];
    assign prog_mode = r_state[3];
    assign led       = r_state[3:0];
    assign entry_cnt = r_entry_cnt;
    assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_param_digital_lock.sv
// Testbench for param_digital_lock with short timer parameters.
module tb_param_digital_lock;

    localparam logic [3:0] D0 = 4'b0001;
    localparam logic [3:0] D1 = 4'b0010;
    localparam logic [3:0] D2 = 4'b0100;
    localparam logic [3:0] D3 = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_pulse = '0;
    logic       relock = 1'b0;
    logic       prog_req = 1'b0;
    logic       unlocked, error, lockout, prog_mode;
    logic [2:0] entry_cnt;
    logic [1:0] fail_cnt;
    logic [3:0] led;

    always #5 clk = ~clk;

    param_digital_lock #(
        .NUM_BUTTONS(4), .CODE_LEN(4), .DEFAULT_CODE(8'hE4), .MAX_TRIES(3),
        .ERR_CYCLES(4), .LOCKOUT_CYCLES(16), .OPEN_CYCLES(20), .ENTRY_TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .relock(relock), .prog_req(prog_req),
        .unlocked(unlocked), .error(error), .lockout(lockout), .prog_mode(prog_mode),
        .entry_cnt(entry_cnt), .fail_cnt(fail_cnt), .led(led)
    );

    typedef struct {
        logic [3:0] btn;
        logic       rl;
        logic       pr;
        logic       rs;
        int         reps;
        logic [3:0] led;
        int         ent;
        int         fail;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] led;
        int         ent;
        int         fail;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [3:0] junk [9];

    function automatic vec_t V(input logic [3:0] b, input logic rl, input logic pr, input logic rs,
                               input int reps, input logic [3:0] l, input int ent, input int fail,
                               input string nm);
        vec_t v;
        v.btn = b; v.rl = rl; v.pr = pr; v.rs = rs; v.reps = reps;
        v.led = l; v.ent = ent; v.fail = fail; v.name = nm;
        return v;
    endfunction

    task automatic check_one(input string nm, input string what, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s/%s: got %0d, expected %0d", nm, what, act, req);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, and compare after the edge.
    task automatic step(input logic [3:0] b, input logic rl, input logic pr, input logic rs,
                        input logic [3:0] l, input int ent, input int fail, input string nm);
        exp_t e;
        @(negedge clk);
        btn_pulse = b; relock = rl; prog_req = pr; rst = rs;
        e.led = l; e.ent = ent; e.fail = fail; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        btn_pulse = '0; relock = 1'b0; prog_req = 1'b0; rst = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s/scoreboard: got empty queue, expected an entry", nm);
        end else begin
            e = sb.pop_front();
            check_one(e.name, "led", int'(led), int'(e.led));
            check_one(e.name, "flags", int'({prog_mode, lockout, error, unlocked}), int'(e.led));
            check_one(e.name, "entry_cnt", int'(entry_cnt), e.ent);
            check_one(e.name, "fail_cnt", int'(fail_cnt), e.fail);
        end
    endtask

    task automatic push_wrong_attempt(input int prev_fail, input int k);
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 1, prev_fail, "bad_d0"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 2, prev_fail, "bad_d1"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 3, prev_fail, "bad_d2"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 4, prev_fail, "bad_d2_last"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0010, 0, k, "fail_enter"));
        tbl.push_back(V(4'b0, 0, 0, 0, 3, 4'b0010, 0, k, "fail_hold"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0000, 0, k, "fail_done"));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        junk = '{4'b0011, 4'b0000, 4'b1111, 4'b0101, 4'b0000, 4'b0011, 4'b1100, 4'b0000, 4'b1001};

        // Reset and basic unlock with auto-relock after 20 cycles.
        tbl.push_back(V(4'b0, 0, 0, 1, 2, 4'b0000, 0, 0, "reset"));
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 1, 0, "t1_d0"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 2, 0, "t1_d1"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 3, 0, "t1_d2"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 4, 0, "t1_check"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0001, 0, 0, "t1_open"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0001, 0, 0, "t1_open_press"));
        tbl.push_back(V(4'b0, 0, 0, 0, 18, 4'b0001, 0, 0, "t1_open_hold"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0000, 0, 0, "t1_autorelock"));

        // Two failures, then lockout on the third; presses during lockout are ignored.
        push_wrong_attempt(0, 1);
        push_wrong_attempt(1, 2);
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 1, 2, "t2_d0"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 2, 2, "t2_d1"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 3, 2, "t2_d2"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 4, 2, "t2_d2_last"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0100, 0, 0, "t2_lockout"));
        tbl.push_back(V(D0, 0, 0, 0, 5, 4'b0100, 0, 0, "t2_lockout_press"));
        tbl.push_back(V(4'b0, 1, 1, 0, 1, 4'b0100, 0, 0, "t2_lockout_relock"));
        tbl.push_back(V(4'b0, 0, 0, 0, 9, 4'b0100, 0, 0, "t2_lockout_hold"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0000, 0, 0, "t2_lockout_done"));

        // Entry timeout keeps fail_cnt, then a correct entry clears it.
        push_wrong_attempt(0, 1);
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 1, 1, "t3_d0"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 2, 1, "t3_d1"));
        tbl.push_back(V(4'b0, 0, 0, 0, 9, 4'b0000, 2, 1, "t3_idle"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0000, 0, 1, "t3_timeout"));
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 1, 1, "t3_d0b"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 2, 1, "t3_d1b"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 3, 1, "t3_d2b"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 4, 1, "t3_check"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0001, 0, 0, "t3_open"));

        // Reprogram to 3,3,1,0; the old code fails and the new one opens.
        tbl.push_back(V(4'b0, 0, 1, 0, 1, 4'b1000, 0, 0, "t4_prog"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b1000, 1, 0, "t4_p3"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b1000, 2, 0, "t4_p3b"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b1000, 3, 0, "t4_p1"));
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 0, 0, "t4_p0_commit"));
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 1, 0, "t4_old_d0"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 2, 0, "t4_old_d1"));
        tbl.push_back(V(D2, 0, 0, 0, 1, 4'b0000, 3, 0, "t4_old_d2"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 4, 0, "t4_old_d3"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0010, 0, 1, "t4_old_fails"));
        tbl.push_back(V(4'b0, 0, 0, 0, 3, 4'b0010, 0, 1, "t4_fail_hold"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0000, 0, 1, "t4_fail_done"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 1, 1, "t4_new_d3"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 2, 1, "t4_new_d3b"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 3, 1, "t4_new_d1"));
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 4, 1, "t4_new_d0"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0001, 0, 0, "t4_new_open"));

        // PROG abort on timeout leaves the code unchanged.
        tbl.push_back(V(4'b0, 0, 1, 0, 1, 4'b1000, 0, 0, "t4b_prog"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b1000, 1, 0, "t4b_p1"));
        tbl.push_back(V(4'b0, 0, 0, 0, 9, 4'b1000, 1, 0, "t4b_idle"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0000, 0, 0, "t4b_abort"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 1, 0, "t4b_d3"));
        tbl.push_back(V(D3, 0, 0, 0, 1, 4'b0000, 2, 0, "t4b_d3b"));
        tbl.push_back(V(D1, 0, 0, 0, 1, 4'b0000, 3, 0, "t4b_d1"));
        tbl.push_back(V(D0, 0, 0, 0, 1, 4'b0000, 4, 0, "t4b_d0"));
        tbl.push_back(V(4'b0, 0, 0, 0, 1, 4'b0001, 0, 0, "t4b_open"));
        tbl.push_back(V(4'b0, 1, 0, 0, 1, 4'b0000, 0, 0, "t4b_relock"));

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].btn, tbl[i].rl, tbl[i].pr, tbl[i].rs,
                     tbl[i].led, tbl[i].ent, tbl[i].fail, tbl[i].name);
            end
        end

        // Invalid presses neither add digits nor restart the entry timer.
        step(D3, 0, 0, 0, 4'b0000, 1, 0, "t5_d3");
        for (int i = 0; i < 9; i++) begin
            step(junk[i], 0, 0, 0, 4'b0000, 1, 0, "t5_invalid");
        end
        step(4'b0, 0, 0, 0, 4'b0000, 0, 0, "t5_timeout");
        step(D3, 0, 0, 0, 4'b0000, 1, 0, "t5_d3b");
        step(D3, 0, 0, 0, 4'b0000, 2, 0, "t5_d3c");
        step(D1, 0, 0, 0, 4'b0000, 3, 0, "t5_d1");
        step(D0, 0, 0, 0, 4'b0000, 4, 0, "t5_d0");
        step(4'b0, 0, 0, 0, 4'b0001, 0, 0, "t5_open");
        step(4'b0, 1, 1, 0, 4'b0000, 0, 0, "t5_relock_wins");
        step(4'b0, 0, 0, 0, 4'b0000, 0, 0, "t5_stays_locked");

        // Reset in the middle of PROG restores the default code.
        step(D3, 0, 0, 0, 4'b0000, 1, 0, "t6_d3");
        step(D3, 0, 0, 0, 4'b0000, 2, 0, "t6_d3b");
        step(D1, 0, 0, 0, 4'b0000, 3, 0, "t6_d1");
        step(D0, 0, 0, 0, 4'b0000, 4, 0, "t6_d0");
        step(4'b0, 0, 0, 0, 4'b0001, 0, 0, "t6_open");
        step(4'b0, 0, 1, 0, 4'b1000, 0, 0, "t6_prog");
        step(D2, 0, 0, 0, 4'b1000, 1, 0, "t6_p2");
        step(D2, 0, 0, 0, 4'b1000, 2, 0, "t6_p2b");
        step(D2, 0, 0, 1, 4'b0000, 0, 0, "t6_rst_in_prog");
        step(D0, 0, 0, 0, 4'b0000, 1, 0, "t6_def_d0");
        step(D1, 0, 0, 0, 4'b0000, 2, 0, "t6_def_d1");
        step(D2, 0, 0, 0, 4'b0000, 3, 0, "t6_def_d2");
        step(D3, 0, 0, 0, 4'b0000, 4, 0, "t6_def_d3");
        step(4'b0, 0, 0, 0, 4'b0001, 0, 0, "t6_default_open");
        step(4'b0, 1, 0, 0, 4'b0000, 0, 0, "t6_relock");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
